// File: rtl/nn_pkg.sv
// Shared constants for the neuron output-decision stage.
// Widths, neuron count and the classifier state encoding live here.
package nn_pkg;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 8;
  localparam int N_NEURONS = 4;
  localparam int CLS_W     = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/neuron_argmax_classifier_if.sv
// Bus between the argmax classifier and its neighbours: start/data in,
// result handshake out, plus the hit-counter statistics port.
interface neuron_argmax_classifier_if
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int CNT_W  = nn_pkg::CNT_W
);

  logic              start;
  logic [DATA_W-1:0] n0;
  logic [DATA_W-1:0] n1;
  logic [DATA_W-1:0] n2;
  logic [DATA_W-1:0] n3;
  logic              result_ready;
  logic              clr_counts;
  logic [CLS_W-1:0]  sel_count;
  logic              busy;
  logic              result_valid;
  logic [CLS_W-1:0]  result_class;
  logic [DATA_W-1:0] result_value;
  logic [CNT_W-1:0]  count_out;
  logic              sat;

  modport master (
    output start, n0, n1, n2, n3, result_ready, clr_counts, sel_count,
    input  busy, result_valid, result_class, result_value, count_out, sat
  );

  modport slave (
    input  start, n0, n1, n2, n3, result_ready, clr_counts, sel_count,
    output busy, result_valid, result_class, result_value, count_out, sat
  );

endinterface

// File: rtl/neuron_argmax_classifier_hit_counter.sv
// Saturating per-class hit counter; a clear beats a coincident increment.
module hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_reg;

  assign sat   = &count_reg;
  assign count = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !sat) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_argmax_classifier.sv
// Snapshots four neuron outputs on start, scans them one per cycle for the
// argmax, presents the winner on valid/ready and counts wins per class.
module neuron_argmax_classifier
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int CNT_W  = nn_pkg::CNT_W
) (
  input logic                         clk,
  input logic                         reset,
  neuron_argmax_classifier_if.slave   bus
);

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] snap_reg [N_NEURONS];
  logic [CLS_W-1:0]  best_idx_reg;
  logic [DATA_W-1:0] best_val_reg;
  logic [CLS_W-1:0]  idx_reg;
  logic              result_valid_reg;
  logic [CLS_W-1:0]  result_class_reg;
  logic [DATA_W-1:0] result_value_reg;

  logic [CLS_W-1:0]  best_idx_next;
  logic [DATA_W-1:0] best_val_next;
  logic              scan_last;

  logic [CNT_W-1:0]  count_vec [N_NEURONS];
  logic [N_NEURONS-1:0] sat_vec;

  // Strict compare: ties keep the earlier (lower) index.
  always_comb begin
    best_idx_next = best_idx_reg;
    best_val_next = best_val_reg;
    if (snap_reg[idx_reg] > best_val_reg) begin
      best_idx_next = idx_reg;
      best_val_next = snap_reg[idx_reg];
    end
  end

  assign scan_last = (state_reg == SCAN) && (idx_reg == CLS_W'(N_NEURONS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      for (int i = 0; i < N_NEURONS; i++) snap_reg[i] <= '0;
      best_idx_reg     <= '0;
      best_val_reg     <= '0;
      idx_reg          <= '0;
      result_valid_reg <= 1'b0;
      result_class_reg <= '0;
      result_value_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            snap_reg[0]  <= bus.n0;
            snap_reg[1]  <= bus.n1;
            snap_reg[2]  <= bus.n2;
            snap_reg[3]  <= bus.n3;
            best_idx_reg <= '0;
            best_val_reg <= bus.n0;
            idx_reg      <= CLS_W'(1);
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          best_idx_reg <= best_idx_next;
          best_val_reg <= best_val_next;
          idx_reg      <= idx_reg + 1'b1;
          if (scan_last) begin
            result_class_reg <= best_idx_next;
            result_value_reg <= best_val_next;
            result_valid_reg <= 1'b1;
            state_reg        <= DONE;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (bus.result_ready) begin
            result_valid_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_cnt
      hit_counter #(.CNT_W(CNT_W)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (scan_last && (best_idx_next == CLS_W'(gi))),
        .clr   (bus.clr_counts),
        .count (count_vec[gi]),
        .sat   (sat_vec[gi])
      );
    end
  endgenerate

  assign bus.busy         = (state_reg != IDLE);
  assign bus.result_valid = result_valid_reg;
  assign bus.result_class = result_class_reg;
  assign bus.result_value = result_value_reg;
  assign bus.count_out    = count_vec[bus.sel_count];
  assign bus.sat          = |sat_vec;

endmodule

// File: tb/tb_neuron_argmax_classifier.sv
// Scoreboard bench for the argmax classifier: stimulus pushes expected
// results, a negedge monitor pops them on each rising result_valid.
module tb_neuron_argmax_classifier;

  logic clk;
  logic rst;

  neuron_argmax_classifier_if bus ();

  neuron_argmax_classifier dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] cls;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one pop per result, detected as a rising result_valid.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.result_valid === 1'b1 && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got class %0d value %0d with nothing expected",
                   bus.result_class, bus.result_value);
        end else begin
          e = q.pop_front();
          check("mon_class", 32'(bus.result_class), 32'(e.cls));
          check("mon_value", 32'(bus.result_value), 32'(e.val));
          $display("result class=%0d value=%0d (expected %0d/%0d)",
                   bus.result_class, bus.result_value, e.cls, e.val);
        end
      end
      prev_valid = (bus.result_valid === 1'b1);
    end
  end

  task automatic check_count(input int sel, input int req, input string name);
    bus.sel_count = 2'(sel);
    #1;
    check(name, 32'(bus.count_out), 32'(req));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.result_valid === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("handshake_timeout", 32'(bus.result_valid), 32'd0);
  endtask

  // One classification with ready held high; inputs are scrambled after
  // the start edge to prove the snapshot is what gets scanned.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] d, input logic [1:0] ec, input logic [7:0] ev,
                     input bit clr_late);
    exp_t e;
    @(negedge clk);
    bus.n0 = a; bus.n1 = b; bus.n2 = c; bus.n3 = d;
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    e.cls = ec;
    e.val = ev;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.n0 = 8'd255; bus.n1 = 8'd0; bus.n2 = 8'd0; bus.n3 = 8'd0;
    @(negedge clk);
    @(negedge clk);
    if (clr_late) bus.clr_counts = 1'b1;
    @(negedge clk);
    bus.clr_counts = 1'b0;
    check("valid_at_n3", 32'(bus.result_valid), 32'd1);
    wait_idle();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_class"}, 32'(bus.result_class), 32'd0);
    check({tag, "_value"}, 32'(bus.result_value), 32'd0);
    for (int s = 0; s < 4; s++) check_count(s, 0, {tag, "_count"});
    check({tag, "_sat"}, 32'(bus.sat), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.n0 = '0; bus.n1 = '0; bus.n2 = '0; bus.n3 = '0;
    bus.result_ready = 1'b0;
    bus.clr_counts = 1'b0;
    bus.sel_count = '0;

    repeat (2) @(negedge clk);
    check_idle_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset");

    // Basic argmax with near-tie at index 3.
    run(8'd10, 8'd200, 8'd50, 8'd199, 2'd1, 8'd200, 1'b0);
    check_count(1, 1, "basic_count1");

    // Ties resolve to the lower index.
    run(8'd7, 8'd7, 8'd7, 8'd7, 2'd0, 8'd7, 1'b0);
    run(8'd0, 8'd5, 8'd5, 8'd0, 2'd1, 8'd5, 1'b0);
    run(8'd0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b0);
    check_count(0, 2, "tie_count0");

    // Backpressure: held result, start ignored, single increment.
    @(negedge clk);
    bus.n0 = 8'd3; bus.n1 = 8'd9; bus.n2 = 8'd4; bus.n3 = 8'd2;
    bus.start = 1'b1;
    bus.result_ready = 1'b0;
    e.cls = 2'd1;
    e.val = 8'd9;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("bp_busy_n", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.result_valid), 32'd1);
      check("bp_class", 32'(bus.result_class), 32'd1);
      check("bp_value", 32'(bus.result_value), 32'd9);
      check("bp_busy",  32'(bus.busy), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    check_count(1, 3, "bp_count1");
    @(negedge clk);
    check("bp_valid_drop", 32'(bus.result_valid), 32'd0);
    check("bp_busy_drop",  32'(bus.busy), 32'd0);
    check("bp_class_hold", 32'(bus.result_class), 32'd1);
    check("bp_value_hold", 32'(bus.result_value), 32'd9);
    run(8'd1, 8'd1, 8'd1, 8'd8, 2'd3, 8'd8, 1'b0);
    check_count(3, 1, "post_bp_count3");

    // Abort a run with reset partway through the scan.
    @(negedge clk);
    bus.n0 = 8'd1; bus.n1 = 8'd2; bus.n2 = 8'd3; bus.n3 = 8'd4;
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_zero("abort");

    // Saturation of class 3, then clear colliding with an increment.
    for (int r = 0; r < 260; r++) run(8'd0, 8'd0, 8'd0, 8'd9, 2'd3, 8'd9, 1'b0);
    check_count(3, 255, "sat_count3");
    check("sat_flag", 32'(bus.sat), 32'd1);
    check_count(0, 0, "sat_count0");
    run(8'd0, 8'd0, 8'd0, 8'd9, 2'd3, 8'd9, 1'b1);
    check_count(3, 0, "clr_count3");
    check("clr_sat", 32'(bus.sat), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/neuron_argmax_classifier.md
Name: neuron_argmax_classifier

Overview:
- Output-decision stage directly downstream of the four perceptrons.
- On a start pulse, snapshots the four neuron outputs and scans them sequentially, one comparison per cycle, to find the winning neuron (argmax).
- Presents class index and value on a valid/ready handshake.
- Keeps per-class saturating hit counters for on-chip statistics, readable through a select port and muxable onto uo_out by the top level.

Parameters:
- DATA_W, 8, width of each neuron output and of result_value.
- CNT_W, 8, width of each per-class hit counter.
- N_NEURONS, 4, number of neurons scanned. Fixed at 4; the class index is 2 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a classification; sampled only in IDLE.
- n0  input  DATA_W  neuron0 output (unsigned).
- n1  input  DATA_W  neuron1 output.
- n2  input  DATA_W  neuron2 output.
- n3  input  DATA_W  neuron3 output.
- result_ready  input  1  consumer accepts result.
- clr_counts  input  1  synchronous clear of all hit counters.
- sel_count  input  2  selects the counter driven on count_out.
- busy  output  1  high whenever state != IDLE.
- result_valid  output  1  result_class/result_value valid.
- result_class  output  2  index of winning neuron.
- result_value  output  DATA_W  value of winning neuron.
- count_out  output  CNT_W  hit_count[sel_count], combinational read.
- sat  output  1  OR of all counters' saturated flags.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - Snapshot, best_idx, best_val, scan index and all counters = 0.
  - All outputs 0 while reset is high and after release.
  - Reset asserted mid-SCAN or mid-DONE aborts immediately. No counter increment for the aborted run.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On start=1 at edge N: latch n0..n3 into snap[0..3], best_idx=0, best_val=n0, idx=1, go to SCAN.
  - n0..n3 changes after edge N have no effect on the result.
- SCAN, edges N+1, N+2, N+3:
  - Compare snap[idx] > best_val (unsigned, strict).
  - If true, update best_idx=idx and best_val=snap[idx].
  - Increment idx.
  - At the edge processing idx=3, go to DONE.
  - Ties keep the lower index.
- Entry to DONE (edge N+3):
  - result_class and result_value are registered from the final best values.
  - result_valid=1 from edge N+3.
  - hit_count[final best_idx] increments once, saturating at 2^CNT_W-1.
- DONE:
  - result_valid, result_class and result_value are held stable until result_valid && result_ready at a rising edge.
  - At that edge, result_valid=0 and state goes to IDLE.
  - result_ready already high on entry: handshake completes at edge N+4, so result_valid is a one-cycle pulse.
  - start is ignored in SCAN and DONE (no queueing).
  - Minimum start-to-start period is 5 cycles (next start sampled at edge N+5).
- After a handshake, result_class and result_value keep their last values; only result_valid drops.
- Counters:
  - clr_counts=1 zeroes all four counters at the next edge.
  - If clr_counts coincides with an increment, clear wins (result 0).
  - sat is combinational: any counter == max.
- busy is registered state decode: 1 from edge N through the handshake edge.

Decomposition:
- Shared package nn_pkg:
  - DATA_W and CNT_W constants.
  - N_NEURONS=4.
  - classifier state encoding IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - class index width constant (2).
- One sub-module: hit_counter (CNT_W saturating counter with inc, clr, clr-priority, sat flag), instantiated four times.
- Compare/select logic stays inline in the FSM.

Test Plan:
- Reset: assert reset mid-run, then release → busy=0, result_valid=0, result_class=0, result_value=0, count_out=0 for every sel_count, sat=0.
- Basic argmax: n=(10,200,50,199), start at edge N; n changed to (255,0,0,0) at N+1 → at edge N+3 result_valid=1, class=1, value=200; sel_count=1 gives count_out=1.
- Ties: (7,7,7,7) → class 0, value 7. (0,5,5,0) → class 1, value 5. (0,0,0,0) → class 0.
- Backpressure: result_ready=0 for 10 cycles after result_valid, start pulsed each cycle → outputs stable, busy=1, counter increments exactly once. Raising ready completes the handshake, then the next start is accepted.
- Saturation/clear: 260 runs with winner 3 → count_out(sel=3)=255, sat=1. Then clr_counts on the same edge as another class-3 increment → count 0, sat=0.
- Abort: reset pulsed at edge N+2 of a run with (1,2,3,4) → state IDLE, result_valid never rises, count_out(sel=3)=0.
